// File: rtl/fireball_ctrl_if.sv
// Signal bundle between the fireball controller, player/opponent state and the fireball sprite.
// The master side drives the game inputs and the slave side (the controller) drives the launch and damage outputs.
interface fireball_ctrl_if;
  logic       frame_tick;
  logic       fire_btn;
  logic       player_busy;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       facing;
  logic [9:0] opponent_x;
  logic [9:0] opponent_y;
  logic       opponent_blocking;
  logic [1:0] fb_state;
  logic [9:0] fb_x;
  logic [9:0] fb_y;
  logic       fb_enable;
  logic       fb_direction;
  logic [9:0] fb_start_x;
  logic [9:0] fb_start_y;
  logic       opponent_hit;
  logic       dmg_valid;
  logic [3:0] dmg_amount;
  logic       ready;
  logic [2:0] ctrl_state;

  modport master (
    output frame_tick, fire_btn, player_busy, player_x, player_y, facing,
           opponent_x, opponent_y, opponent_blocking, fb_state, fb_x, fb_y,
    input  fb_enable, fb_direction, fb_start_x, fb_start_y, opponent_hit,
           dmg_valid, dmg_amount, ready, ctrl_state
  );

  modport slave (
    input  frame_tick, fire_btn, player_busy, player_x, player_y, facing,
           opponent_x, opponent_y, opponent_blocking, fb_state, fb_x, fb_y,
    output fb_enable, fb_direction, fb_start_x, fb_start_y, opponent_hit,
           dmg_valid, dmg_amount, ready, ctrl_state
  );
endinterface

// File: rtl/fireball_ctrl.sv
// Fireball launch / hit-scoring controller: launches on a fire-button rising edge,
// scores at most one hit per launch, and enforces a frame-counted cooldown between launches.
module fireball_ctrl #(
  parameter int SPRITE_WIDTH    = 32,
  parameter int SPRITE_HEIGHT   = 64,
  parameter int COOLDOWN_FRAMES = 60,
  parameter int HIT_HOLD        = 4,
  parameter int FULL_DMG        = 10,
  parameter int BLOCK_DMG       = 2
) (
  input logic           clk,
  input logic           start,
  fireball_ctrl_if.slave fb
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    FLIGHT   = 3'd2,
    WAIT_END = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  localparam logic [1:0] FB_DIS  = 2'd0;
  localparam logic [1:0] FB_EN   = 2'd1;
  localparam logic [1:0] FB_EXPL = 2'd2;

  localparam int CDW = $clog2(COOLDOWN_FRAMES + 1);
  localparam int HDW = $clog2(HIT_HOLD + 1);
  localparam logic [CDW-1:0] CD_LAST   = CDW'(COOLDOWN_FRAMES - 1);
  localparam logic [HDW-1:0] HOLD_LAST = HDW'(HIT_HOLD - 1);
  localparam logic [10:0]    HALF_W    = 11'(SPRITE_WIDTH / 2);
  localparam logic [10:0]    SPR_H     = 11'(SPRITE_HEIGHT);
  localparam logic [3:0]     FULL_AMT  = 4'(FULL_DMG);
  localparam logic [3:0]     BLOCK_AMT = 4'(BLOCK_DMG);

  state_t         state, state_n;
  logic           fire_q;
  logic [1:0]     launch_cnt;
  logic [CDW-1:0] cd_cnt;
  logic [HDW-1:0] hold_cnt;
  logic           fb_enable_q, fb_dir_q, opp_hit_q, dmg_valid_q;
  logic [9:0]     start_x_q, start_y_q;
  logic [3:0]     dmg_amt_q;

  logic        launch_evt, go, hit, hit_fire;
  logic [10:0] ox, oy, fx, fy, xl, xr, yt;

  assign launch_evt = fb.fire_btn & ~fire_q;
  assign go         = (state == IDLE) & launch_evt & ~fb.player_busy;

  // Overlap test in 11 bits so the right/bottom bounds cannot wrap; left/top clamp at 0.
  assign ox  = {1'b0, fb.opponent_x};
  assign oy  = {1'b0, fb.opponent_y};
  assign fx  = {1'b0, fb.fb_x};
  assign fy  = {1'b0, fb.fb_y};
  assign xl  = (ox >= HALF_W) ? ox - HALF_W : 11'd0;
  assign xr  = ox + HALF_W;
  assign yt  = (oy + 11'd1 >= SPR_H) ? oy + 11'd1 - SPR_H : 11'd0;
  assign hit = (fx >= xl) && (fx <= xr) && (fy >= yt) && (fy <= oy);
  assign hit_fire = (state == FLIGHT) && hit;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (go) state_n = LAUNCH;
      LAUNCH: begin
        if (fb.fb_state == FB_EN)      state_n = FLIGHT;
        else if (launch_cnt == 2'd3)   state_n = COOLDOWN;
      end
      FLIGHT: begin
        if (hit)                           state_n = WAIT_END;
        else if (fb.fb_state == FB_EXPL)   state_n = WAIT_END;
        else if (fb.fb_state == FB_DIS)    state_n = COOLDOWN;
      end
      WAIT_END: if (fb.fb_state == FB_DIS) state_n = COOLDOWN;
      COOLDOWN: if (fb.frame_tick && cd_cnt == CD_LAST) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state       <= IDLE;
      fire_q      <= 1'b1;   // a button held through reset must not look like a fresh press
      launch_cnt  <= '0;
      cd_cnt      <= '0;
      hold_cnt    <= '0;
      fb_enable_q <= 1'b0;
      fb_dir_q    <= 1'b0;
      start_x_q   <= '0;
      start_y_q   <= '0;
      opp_hit_q   <= 1'b0;
      dmg_valid_q <= 1'b0;
      dmg_amt_q   <= '0;
    end else begin
      state       <= state_n;
      fire_q      <= fb.fire_btn;
      fb_enable_q <= (state_n == LAUNCH);
      launch_cnt  <= (state == LAUNCH) ? launch_cnt + 2'd1 : 2'd0;
      if (go) begin
        start_x_q <= fb.player_x;
        start_y_q <= fb.player_y;
        fb_dir_q  <= fb.facing;
      end
      if (state_n == COOLDOWN && state != COOLDOWN) cd_cnt <= '0;
      else if (state == COOLDOWN && fb.frame_tick)  cd_cnt <= cd_cnt + CDW'(1);
      dmg_valid_q <= hit_fire;
      if (hit_fire) dmg_amt_q <= fb.opponent_blocking ? BLOCK_AMT : FULL_AMT;
      // The hold counter runs on its own so the pulse length is independent of state changes.
      if (hit_fire) begin
        opp_hit_q <= 1'b1;
        hold_cnt  <= HOLD_LAST;
      end else if (opp_hit_q) begin
        if (hold_cnt == '0) opp_hit_q <= 1'b0;
        else                hold_cnt  <= hold_cnt - HDW'(1);
      end
    end
  end

  assign fb.fb_enable    = fb_enable_q;
  assign fb.fb_direction = fb_dir_q;
  assign fb.fb_start_x   = start_x_q;
  assign fb.fb_start_y   = start_y_q;
  assign fb.opponent_hit = opp_hit_q;
  assign fb.dmg_valid    = dmg_valid_q;
  assign fb.dmg_amount   = dmg_amt_q;
  assign fb.ready        = (state == IDLE);
  assign fb.ctrl_state   = state;
endmodule

// File: doc/fireball_ctrl.md
FIREBALL_CTRL -- requirements
Module: fireball_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SPRITE_WIDTH, 32, opponent hitbox width in pixels.
- SPRITE_HEIGHT, 64, opponent hitbox height in pixels.
- COOLDOWN_FRAMES, 60, frame_tick pulses between fireball end and the next launch.
- HIT_HOLD, 4, cycles opponent_hit stays high.
- FULL_DMG, 10, damage for an unblocked hit.
- BLOCK_DMG, 2, damage for a blocked hit.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single system clock; all logic on its rising edge.
- start, in, 1, synchronous active-high reset.
- frame_tick, in, 1, one-cycle pulse per video frame.
- fire_btn, in, 1, player fire button, level.
- player_busy, in, 1, player mid-animation; launch is inhibited.
- player_x, in, 10, player launch x.
- player_y, in, 10, player launch y.
- facing, in, 1, 1 = right, 0 = left.
- opponent_x, in, 10, opponent centre x.
- opponent_y, in, 10, opponent feet y.
- opponent_blocking, in, 1, opponent is guarding.
- fb_state, in, 2, fireball state: 0 DISABLED, 1 ENABLED, 2 EXPLOSION.
- fb_x, in, 10, fireball x.
- fb_y, in, 10, fireball y.
- fb_enable, out, 1, launch request to the fireball.
- fb_direction, out, 1, latched launch direction.
- fb_start_x, out, 10, latched launch x.
- fb_start_y, out, 10, latched launch y.
- opponent_hit, out, 1, hit notification to the fireball.
- dmg_valid, out, 1, one-cycle damage pulse.
- dmg_amount, out, 4, damage value, valid with dmg_valid.
- ready, out, 1, high only in IDLE.
- ctrl_state, out, 3, current FSM state for debug.

Function
REQ-003 FSM states and encodings: IDLE=0, LAUNCH=1, FLIGHT=2, WAIT_END=3, COOLDOWN=4; ctrl_state equals the registered state.
REQ-004 fire_btn is registered once; a launch event is registered-low followed by current-high, i.e. a rising edge.
REQ-005 IDLE: on a launch event with player_busy=0, next cycle:
- latch fb_start_x=player_x, fb_start_y=player_y, fb_direction=facing;
- enter LAUNCH.
A launch event while player_busy=1 is discarded, not queued.
REQ-006 fb_start_x, fb_start_y and fb_direction are held constant from the latch until the next IDLE->LAUNCH latch.
REQ-007 LAUNCH: fb_enable=1 (registered); exits:
- fb_state==ENABLED: go to FLIGHT and drop fb_enable.
- 4 cycles in LAUNCH without ENABLED: abort to COOLDOWN and drop fb_enable.
REQ-008 FLIGHT: hit test every cycle, done in 11-bit unsigned arithmetic:
- hit = (xl <= fb_x <= opponent_x+SPRITE_WIDTH/2) AND (yt <= fb_y <= opponent_y).
- xl = opponent_x-SPRITE_WIDTH/2, clamped to 0 on underflow.
- yt = opponent_y-SPRITE_HEIGHT+1, clamped to 0 on underflow.
REQ-009 FLIGHT hit: next cycle:
- opponent_hit=1 for exactly HIT_HOLD cycles;
- dmg_valid=1 for one cycle, dmg_amount = opponent_blocking (sampled on the hit cycle) ? BLOCK_DMG : FULL_DMG;
- enter WAIT_END.
REQ-010 FLIGHT, fb_state==EXPLOSION without hit (wall): enter WAIT_END with no damage and no opponent_hit.
REQ-011 Hit and EXPLOSION in the same cycle: the hit wins (REQ-009).
REQ-012 FLIGHT, fb_state==DISABLED: enter COOLDOWN directly.
REQ-013 Only one hit is scored per launch; hit tests are not evaluated outside FLIGHT.
REQ-014 WAIT_END: stay until fb_state==DISABLED, then enter COOLDOWN; opponent_hit completes its HIT_HOLD count independent of state changes.
REQ-015 COOLDOWN: counter cleared on entry, incremented on each frame_tick; at COOLDOWN_FRAMES enter IDLE. fire_btn edges during COOLDOWN are ignored.
REQ-016 ready=1 iff state==IDLE.
REQ-017 dmg_amount holds its last value between pulses.

Reset
REQ-018 start=1 at a clock edge, in any state, sets:
- state=IDLE; fb_enable=0; opponent_hit=0; dmg_valid=0; dmg_amount=0;
- fb_start_x=0; fb_start_y=0; fb_direction=0;
- all counters 0; fire_btn register=1, so a held button does not fire after reset.
REQ-019 Reset takes priority over every other event in the same cycle.

Verification
REQ-020 Launch: player_x=100, player_y=300, facing=1, fire_btn rises; fb_state->1 two cycles later -> fb_start_x=100, fb_start_y=300, fb_direction=1, fb_enable high exactly during LAUNCH, state FLIGHT.
REQ-021 Hit: opponent_x=200, opponent_y=300, fb_x sweeps 180->184 at fb_y=298 -> at fb_x=184 opponent_hit high for 4 cycles, one dmg_valid with dmg_amount=10; with opponent_blocking=1, dmg_amount=2.
REQ-022 Wall: fb_state->2 with no overlap -> no dmg_valid; fb_state->0 -> COOLDOWN; exactly 60 frame_ticks later ready=1.
REQ-023 Edges: opponent_x=5, opponent_y=20 with fb_x=0, fb_y=0 -> hit (clamped bounds); hit and EXPLOSION same cycle -> damage issued.
REQ-024 Abort and inhibit: fb_state stays 0 for 4 LAUNCH cycles -> COOLDOWN, fb_enable=0; fire_btn rise with player_busy=1 or during COOLDOWN -> no launch.
REQ-025 Reset mid-FLIGHT with fire_btn held -> all outputs at REQ-018 values next cycle, no launch until fire_btn is released and pressed again.
